game_menu_select: RTL and testbench
===================================

# game_menu_select

Parametrised menu-screen renderer and selector for the VGA game front end, generalising the fixed speed-selection page to NUM_ITEMS selectable text rows. It draws each item's bitmap from an external glyph ROM, highlights the current item with an optional per-frame blink, and moves the cursor on debounced key pulses. On confirm it issues a one-cycle selection strobe to the game controller. It sits between the VGA timing generator (pixel_xpos/pixel_ypos) and the pixel mux, in the vga_clk_25 domain.

## Interface
- NUM_ITEMS, 4, number of menu rows (2..8)
- ITEM_X, 258, left pixel column of all item rows
- ITEM_Y0, 210, top pixel line of item 0
- ITEM_PITCH, 30, vertical distance between consecutive item tops (≥ ITEM_H)
- ITEM_W, 120, item bitmap width in pixels = glyph_bits width
- ITEM_H, 24, item bitmap height in lines
- DEFAULT_SEL, 0, cursor index after reset / menu_en low
- BLINK_FRAMES, 30, frames per blink half-period (≥1)
- FG_COLOR, 16'h0000, RGB565 unselected glyph pixel
- HL_COLOR, 16'h001F, RGB565 selected glyph pixel
- BG_COLOR, 16'hFFFF, RGB565 background
- Derived: IDX_W = clog2(NUM_ITEMS), ADDR_W = clog2(NUM_ITEMS*ITEM_H)

- vga_clk_25  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_xpos  in  10  current pixel column
- pixel_ypos  in  10  current pixel line
- menu_en  in  1  menu active; low forces idle/reset of selection state
- key_up  in  1  one-cycle debounced pulse, cursor up
- key_down  in  1  one-cycle debounced pulse, cursor down
- key_ok  in  1  one-cycle debounced pulse, confirm
- glyph_addr  out  ADDR_W  ROM line address, item*ITEM_H + line
- glyph_bits  in  ITEM_W  ROM data, 1-cycle synchronous read, MSB = leftmost pixel
- pixel_data  out  16  RGB565 pixel, registered
- sel_item  out  IDX_W  confirmed item index
- sel_valid  out  1  one-cycle confirm strobe
- cur_idx  out  IDX_W  live cursor index

## Operation
- Region: item i active when ITEM_X ≤ x < ITEM_X+ITEM_W and ITEM_Y0+i*ITEM_PITCH ≤ y < that+ITEM_H; rows never overlap. Offsets x_cnt = x−ITEM_X, y_cnt = y−row top; bit index = ITEM_W−1−x_cnt.
- glyph_addr combinational from current coords: i*ITEM_H+y_cnt when in a region, else 0.
- Cursor FSM states: IDLE (menu_en low), BROWSE, LOCKED.
  - IDLE→BROWSE when menu_en high; cur_idx = DEFAULT_SEL.
  - BROWSE: key_up: cur_idx−1, 0 wraps to NUM_ITEMS−1; key_down: +1, NUM_ITEMS−1 wraps to 0. key_up and key_down together: ignored. key_ok (any combination): sel_item ← cur_idx, sel_valid=1 next cycle, →LOCKED, moves in that cycle ignored.
  - LOCKED: all keys ignored; cursor and sel_item frozen.
  - Any state, menu_en low: →IDLE, cur_idx=DEFAULT_SEL, blink reset; sel_item holds.
- Display selection disp_idx latched from cur_idx at frame_start only (no mid-frame tearing). frame_start = rising edge of (x==0 && y==0).
- Colour: in region and bit set → HL_COLOR if item==disp_idx and hl_on, else FG_COLOR; otherwise BG_COLOR. menu_en low → BG_COLOR everywhere.

## Timing
- Reset: pixel_data=BG_COLOR, cur_idx=sel_item=DEFAULT_SEL, sel_valid=0, FSM=IDLE, blink counter 0, blink phase 1.
- Pixel latency 2 clocks: coords at cycle t → ROM data valid t+1 → pixel_data registered at edge ending t+1 (valid t+2). Region flag, item index and bit index pipelined one stage alongside ROM.
- Key effect on cur_idx: 1 clock. sel_valid asserted exactly 1 clock, cycle after key_ok.
- Cursor change visible from the next frame_start.
- Reset asserted mid-frame: outputs return to reset values immediately; no strobe.

## Configuration
- MENU_BLINK_EN defined: frame counter counts frame_starts 0..BLINK_FRAMES−1, toggles hl_on on wrap; hl_on=0 shows selected row in FG_COLOR. In LOCKED, hl_on forced 1 (steady highlight).
- Undefined: no counter; hl_on constant 1.

## Test plan
- Reset, menu_en=1, ROM returns all-ones: pixel (258,210) → HL_COLOR 2 clocks later; (258,240) → FG_COLOR; (0,0) → BG_COLOR; glyph_addr at (300,245) = 1*24+5=29.
- cur_idx=0, key_up pulse → cur_idx=3; four key_down → 3; up+down same cycle → unchanged.
- key_down then key_ok same cycle as key_up → sel_valid one cycle, sel_item=cur_idx value, later keys ignored; menu_en low→high restores BROWSE, cur_idx=0.
- key_down mid-frame → row 0 stays highlighted until next frame_start, then row 1 highlighted.
- MENU_BLINK_EN, BLINK_FRAMES=2: selected row HL for 2 frames, FG for 2, repeat; after key_ok steady HL. Without macro: always HL.
- rst_n low mid-frame during LOCKED → pixel_data=BG_COLOR, sel_valid=0, cur_idx=0 asynchronously.

Source files
------------

// File: rtl/game_menu_select.sv
// Menu-screen renderer and cursor selector in the vga_clk_25 domain.
// Optional per-frame highlight blink is enabled by defining MENU_BLINK_EN.
module game_menu_select #(
  parameter int          NUM_ITEMS    = 4,
  parameter int          ITEM_X       = 258,
  parameter int          ITEM_Y0      = 210,
  parameter int          ITEM_PITCH   = 30,
  parameter int          ITEM_W       = 120,
  parameter int          ITEM_H       = 24,
  parameter int          DEFAULT_SEL  = 0,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] FG_COLOR     = 16'h0000,
  parameter logic [15:0] HL_COLOR     = 16'h001F,
  parameter logic [15:0] BG_COLOR     = 16'hFFFF,
  parameter int          IDX_W        = $clog2(NUM_ITEMS),
  parameter int          ADDR_W       = $clog2(NUM_ITEMS * ITEM_H)
) (
  input  logic              vga_clk_25,
  input  logic              rst_n,
  input  logic [9:0]        pixel_xpos,
  input  logic [9:0]        pixel_ypos,
  input  logic              menu_en,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_ok,
  output logic [ADDR_W-1:0] glyph_addr,
  input  logic [ITEM_W-1:0] glyph_bits,
  output logic [15:0]       pixel_data,
  output logic [IDX_W-1:0]  sel_item,
  output logic              sel_valid,
  output logic [IDX_W-1:0]  cur_idx,
  output logic [1:0]        dbg_state
);

  localparam int BIT_W = $clog2(ITEM_W);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]      X_LO    = 11'(ITEM_X);
  localparam logic [10:0]      X_HI    = 11'(ITEM_X + ITEM_W);
  localparam logic [10:0]      ROW_H   = 11'(ITEM_H);
  localparam logic [10:0]      BIT_TOP = 11'(ITEM_W - 1);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_SEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BROWSE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // ---------------- region decode (combinational from live coordinates)
  logic [10:0]       x_ext, y_ext, x_off, y_off, row_top;
  logic              in_region;
  logic [IDX_W-1:0]  item_idx;
  logic [BIT_W-1:0]  bit_idx;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    x_ext     = {1'b0, pixel_xpos};
    y_ext     = {1'b0, pixel_ypos};
    x_off     = x_ext - X_LO;
    bit_idx   = BIT_W'(BIT_TOP - x_off);
    in_region = 1'b0;
    item_idx  = '0;
    y_off     = '0;
    addr_c    = '0;
    row_top   = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      row_top = 11'(ITEM_Y0 + i * ITEM_PITCH);
      if (x_ext >= X_LO && x_ext < X_HI &&
          y_ext >= row_top && y_ext < row_top + ROW_H) begin
        in_region = 1'b1;
        item_idx  = IDX_W'(i);
        y_off     = y_ext - row_top;
        addr_c    = ADDR_W'(i * ITEM_H) + ADDR_W'(y_off);
      end
    end
  end

  assign glyph_addr = addr_c;

  // ---------------- frame start detection
  logic origin, origin_q, frame_start;

  assign origin      = (pixel_xpos == 10'd0) && (pixel_ypos == 10'd0);
  assign frame_start = origin && !origin_q;

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) origin_q <= 1'b0;
    else        origin_q <= origin;
  end

  // ---------------- cursor FSM
  // sel_valid is a one-cycle strobe qualifying sel_item; there is no ready,
  // the consumer must take sel_item in the cycle sel_valid is high.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_d, sel_d;
  logic             sel_valid_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_idx;
    sel_d       = sel_item;
    sel_valid_d = 1'b0;
    if (!menu_en) begin
      state_d = S_IDLE;
      cur_d   = DEF_IDX;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BROWSE;
          cur_d   = DEF_IDX;
        end
        S_BROWSE: begin
          if (key_ok) begin
            state_d     = S_LOCKED;
            sel_d       = cur_idx;
            sel_valid_d = 1'b1;
          end else if (key_up && !key_down) begin
            cur_d = (cur_idx == '0) ? LAST_IDX : cur_idx - IDX_W'(1);
          end else if (key_down && !key_up) begin
            cur_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
          end
        end
        S_LOCKED: begin
          state_d = S_LOCKED;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_idx   <= DEF_IDX;
      sel_item  <= DEF_IDX;
      sel_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx   <= cur_d;
      sel_item  <= sel_d;
      sel_valid <= sel_valid_d;
    end
  end

  assign dbg_state = state_q;

  // Highlighted row only changes on a frame boundary to avoid tearing.
  logic [IDX_W-1:0] disp_idx;

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n)           disp_idx <= DEF_IDX;
    else if (!menu_en)    disp_idx <= DEF_IDX;
    else if (frame_start) disp_idx <= cur_idx;
  end

  // ---------------- highlight blink
  logic hl_on;

`ifdef MENU_BLINK_EN
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!menu_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  assign hl_on = blink_phase || (state_q == S_LOCKED);
`else
  assign hl_on = 1'b1;
`endif

  // ---------------- pixel pipeline: decode travels alongside the ROM read
  logic             region_q;
  logic [IDX_W-1:0] item_q;
  logic [BIT_W-1:0] bit_q;

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= 1'b0;
      item_q   <= '0;
      bit_q    <= '0;
    end else begin
      region_q <= in_region && menu_en;
      item_q   <= item_idx;
      bit_q    <= bit_idx;
    end
  end

  always_ff @(posedge vga_clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data <= BG_COLOR;
    end else if (region_q && glyph_bits[bit_q]) begin
      pixel_data <= (item_q == disp_idx && hl_on) ? HL_COLOR : FG_COLOR;
    end else begin
      pixel_data <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_game_menu_select.sv
// Self-checking bench for game_menu_select: directed steps plus randomized
// keys/coordinates scored against a frame-level behavioural model.
module tb_game_menu_select;

  localparam int          N    = 4;
  localparam int          IX   = 258;
  localparam int          IY0  = 210;
  localparam int          IP   = 30;
  localparam int          IW   = 120;
  localparam int          IH   = 24;
  localparam int          DEF  = 0;
  localparam int          BF   = 30;
  localparam logic [15:0] FG   = 16'h0000;
  localparam logic [15:0] HL   = 16'h001F;
  localparam logic [15:0] BG   = 16'hFFFF;
  localparam int          IDXW = 2;
  localparam int          AW   = 7;

  // ---------------- clock / reset / DUT
  logic            vga_clk_25 = 1'b0;
  logic            rst_n      = 1'b0;
  logic [9:0]      pixel_xpos = '0;
  logic [9:0]      pixel_ypos = '0;
  logic            menu_en    = 1'b0;
  logic            key_up     = 1'b0;
  logic            key_down   = 1'b0;
  logic            key_ok     = 1'b0;
  logic [AW-1:0]   glyph_addr;
  logic [IW-1:0]   glyph_bits = '0;
  logic [15:0]     pixel_data;
  logic [IDXW-1:0] sel_item;
  logic            sel_valid;
  logic [IDXW-1:0] cur_idx;
  logic [1:0]      dbg_state;

  always #20 vga_clk_25 = ~vga_clk_25;

  game_menu_select #(
    .NUM_ITEMS(N), .ITEM_X(IX), .ITEM_Y0(IY0), .ITEM_PITCH(IP),
    .ITEM_W(IW), .ITEM_H(IH), .DEFAULT_SEL(DEF), .BLINK_FRAMES(BF),
    .FG_COLOR(FG), .HL_COLOR(HL), .BG_COLOR(BG)
  ) dut (
    .vga_clk_25(vga_clk_25), .rst_n(rst_n),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .menu_en(menu_en), .key_up(key_up), .key_down(key_down), .key_ok(key_ok),
    .glyph_addr(glyph_addr), .glyph_bits(glyph_bits),
    .pixel_data(pixel_data), .sel_item(sel_item), .sel_valid(sel_valid),
    .cur_idx(cur_idx), .dbg_state(dbg_state)
  );

  // Glyph ROM with one-cycle synchronous read
  logic [IW-1:0] rom [N*IH];

  always @(posedge vga_clk_25) glyph_bits <= rom[glyph_addr];

  // ---------------- behavioural model + scoreboard
  int          errors = 0;
  int          checks = 0;
  bit          m_active, m_locked, m_phase, m_sv, m_origin_prev;
  int          m_cur, m_sel, m_disp, m_cnt;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_addr(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      int top = IY0 + i * IP;
      if (x >= IX && x < IX + IW && y >= top && y < top + IH) return i * IH + (y - top);
    end
    return 0;
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y, input bit en,
                                          input int disp, input bit hl);
    logic [IW-1:0] line;
    if (!en) return BG;
    for (int i = 0; i < N; i++) begin
      int top = IY0 + i * IP;
      if (x >= IX && x < IX + IW && y >= top && y < top + IH) begin
        line = rom[i * IH + (y - top)];
        if (!line[IW - 1 - (x - IX)]) return BG;
        return (i == disp && hl) ? HL : FG;
      end
    end
    return BG;
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_phase = 1; m_sv = 0; m_origin_prev = 0;
    m_cur = DEF; m_sel = DEF; m_disp = DEF; m_cnt = 0;
    exp_q.delete();
    exp_q.push_back(BG);
  endtask

  task automatic fill_rom(input bit ones);
    for (int a = 0; a < N * IH; a++)
      rom[a] = ones ? '1 : IW'({$urandom, $urandom, $urandom, $urandom});
  endtask

  // ---------------- driver tasks
  task automatic do_reset();
    rst_n = 1'b0; menu_en = 1'b0; key_up = 0; key_down = 0; key_ok = 0;
    pixel_xpos = 10'd5; pixel_ypos = 10'd5;
    repeat (2) @(posedge vga_clk_25);
    #5;
    check("rst_pixel", pixel_data, BG);
    check("rst_cur", cur_idx, DEF);
    check("rst_sel_item", sel_item, DEF);
    check("rst_sel_valid", sel_valid, 0);
    @(negedge vga_clk_25);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model over the edge, score outputs.
  task automatic step(input bit en, input bit up, input bit down, input bit ok,
                      input int x, input int y);
    bit origin, fs, hl;
    menu_en = en; key_up = up; key_down = down; key_ok = ok;
    pixel_xpos = 10'(x); pixel_ypos = 10'(y);
    #1;
    check("glyph_addr", glyph_addr, exp_addr(x, y));
    @(posedge vga_clk_25);
    origin = (x == 0 && y == 0);
    fs = origin && !m_origin_prev;
    m_origin_prev = origin;
    m_sv = 0;
    if (!en) begin
      m_active = 0; m_locked = 0; m_cur = DEF; m_disp = DEF; m_cnt = 0; m_phase = 1;
    end else begin
      if (fs) begin
        m_disp = m_cur;
        if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = !m_phase; end
        else m_cnt++;
      end
      if (!m_active) begin
        m_active = 1; m_cur = DEF;
      end else if (!m_locked) begin
        if (ok) begin m_sel = m_cur; m_sv = 1; m_locked = 1; end
        else if (up && !down) m_cur = (m_cur + N - 1) % N;
        else if (down && !up) m_cur = (m_cur + 1) % N;
      end
    end
`ifdef MENU_BLINK_EN
    hl = m_phase || m_locked;
`else
    hl = 1;
`endif
    #1;
    check("cur_idx", cur_idx, m_cur);
    check("sel_valid", sel_valid, m_sv);
    check("sel_item", sel_item, m_sel);
    if (exp_q.size() == 0) check("pixel_queue", 1, 0);
    else check("pixel", pixel_data, exp_q.pop_front());
    exp_q.push_back(exp_pix(x, y, en, m_disp, hl));
    key_up = 0; key_down = 0; key_ok = 0;
  endtask

  task automatic frame(input bit en);
    step(en, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed + random sequence
  initial begin
    int r, x, y;
    fill_rom(1);
    model_reset();
    do_reset();

    // Basic rendering with an all-ones ROM
    step(1, 0, 0, 0, 258, 210);
    step(1, 0, 0, 0, 258, 240);
    check("row0_hl", pixel_data, HL);
    step(1, 0, 0, 0, 0, 0);
    check("row1_fg", pixel_data, FG);
    step(1, 0, 0, 0, 5, 5);
    check("origin_bg", pixel_data, BG);
    pixel_xpos = 10'd300; pixel_ypos = 10'd245;
    #1;
    check("addr_300_245", glyph_addr, 29);
    step(1, 0, 0, 0, 300, 245);

    // Cursor wrap and simultaneous up/down
    step(1, 1, 0, 0, 5, 5);
    check("up_wrap", cur_idx, 3);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 5, 5);
    check("four_down", cur_idx, 3);
    step(1, 1, 1, 0, 5, 5);
    check("up_down_ignored", cur_idx, 3);

    // Confirm with simultaneous move, then lock
    step(1, 0, 1, 0, 5, 5);
    step(1, 0, 1, 0, 5, 5);
    step(1, 1, 0, 1, 5, 5);
    check("confirm_strobe", sel_valid, 1);
    check("confirm_item", sel_item, 1);
    step(1, 0, 1, 0, 5, 5);
    check("strobe_one_cycle", sel_valid, 0);
    check("locked_cursor", cur_idx, 1);
    step(0, 0, 0, 0, 5, 5);
    step(1, 0, 0, 0, 5, 5);
    check("reenter_default", cur_idx, DEF);
    step(1, 0, 1, 0, 5, 5);
    check("browse_again", cur_idx, 1);

    // Highlight change only at frame start
    frame(1);
    step(1, 1, 0, 0, 5, 5);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 258, 210);
      step(1, 0, 0, 0, 258, 240);
    end
    frame(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 258, 210);
      step(1, 0, 0, 0, 377, 263);
    end

    // Randomized keys, coordinates and frames against random glyph data
    fill_rom(0);
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 39) == 0) begin
        frame(r >= 2);
      end else begin
        x = $urandom_range(250, 385);
        y = $urandom_range(200, 330);
        step(r >= 2, (r >= 2 && r < 10) || (r >= 19 && r < 22),
             (r >= 10 && r < 18) || (r >= 19 && r < 22), r == 18, x, y);
      end
    end

    // Asynchronous reset while locked with a lit pixel on screen
    fill_rom(1);
    do_reset();
    step(1, 0, 0, 0, 5, 5);
    step(1, 0, 1, 0, 5, 5);
    frame(1);
    step(1, 0, 0, 0, 258, 240);
    step(1, 0, 0, 1, 258, 240);
    check("pre_rst_pixel", pixel_data, HL);
    check("pre_rst_strobe", sel_valid, 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_pixel", pixel_data, BG);
    check("async_strobe", sel_valid, 0);
    check("async_cur", cur_idx, DEF);
    check("async_sel_item", sel_item, DEF);
    @(negedge vga_clk_25);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 260 + i, 212);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
